mult_div_unit: RTL and testbench

Multiply/divide unit in the EX stage, directly downstream of the general register file: it consumes the two register read operands (already forwarded) and owns the architectural HI/LO registers. It models fixed MIPS multi-cycle latency with a busy counter. The hazard unit uses `start | busy` to stall any later HI/LO-touching instruction in ID.

---
 rtl/mdu_if.sv | 12 +
 rtl/mult_div_unit.sv | 90 +++++++++
 tb/tb_mult_div_unit.sv | 124 ++++++++++++
 3 files changed

// File: rtl/mdu_if.sv
// mdu_if: issue/result bundle between the EX stage and mult_div_unit
interface mdu_if;
    logic        start;
    logic [3:0]  op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;
    modport master (output start, op, src_a, src_b, input busy, hi, lo);
    modport slave  (input start, op, src_a, src_b, output busy, hi, lo);
endinterface

// File: rtl/mult_div_unit.sv
// mult_div_unit: fixed-latency MIPS multiply/divide unit owning HI/LO; define MDU_MADD_EN for MADD/MSUB ops
module mult_div_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input logic  clk,
    input logic  reset,
    mdu_if.slave m
);
    typedef enum logic {IDLE, BUSY} state_t;
    state_t             state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    logic [31:0]        hi_q, hi_d, lo_q, lo_d;
    logic [31:0]        pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
    logic               is_mul, is_div, is_madd, is_sgn, div0;
    logic signed [32:0] ext_a, ext_b;
    logic signed [63:0] prod;
    logic [31:0]        abs_a, abs_b, q_u, r_u, quo, rem;
    logic [63:0]        res;
    assign is_mul = m.op == 4'd1 || m.op == 4'd2;
    assign is_div = m.op == 4'd3 || m.op == 4'd4;
    assign is_sgn = m.op == 4'd1 || m.op == 4'd3 || m.op == 4'd7 || m.op == 4'd9;
    assign div0   = m.src_b == 32'd0;
    assign ext_a  = {is_sgn & m.src_a[31], m.src_a};
    assign ext_b  = {is_sgn & m.src_b[31], m.src_b};
    assign prod   = ext_a * ext_b;
    assign abs_a  = (is_sgn & m.src_a[31]) ? -m.src_a : m.src_a;
    assign abs_b  = (is_sgn & m.src_b[31]) ? -m.src_b : m.src_b;
    assign q_u    = abs_a / abs_b;
    assign r_u    = abs_a % abs_b;
    assign quo    = (is_sgn & (m.src_a[31] ^ m.src_b[31])) ? -q_u : q_u;
    assign rem    = (is_sgn & m.src_a[31]) ? -r_u : r_u;
`ifdef MDU_MADD_EN
    logic        is_sub;
    logic [63:0] acc;
    assign is_madd = m.op >= 4'd7 && m.op <= 4'd10;
    assign is_sub  = m.op == 4'd9 || m.op == 4'd10;
    assign acc     = is_sub ? {hi_q, lo_q} - prod : {hi_q, lo_q} + prod;
    assign res     = is_div ? (div0 ? {hi_q, lo_q} : {rem, quo}) : is_madd ? acc : prod;
`else
    assign is_madd = 1'b0;
    assign res     = is_div ? (div0 ? {hi_q, lo_q} : {rem, quo}) : prod;
`endif
    // issue decode, busy countdown and HI/LO commit
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
        if (state_q == IDLE) begin
            if (m.start && (is_mul || is_div || is_madd)) begin
                {pend_hi_d, pend_lo_d} = res;
                cnt_d   = is_div ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);
                state_d = BUSY;
            end
            hi_d = (m.start && m.op == 4'd5) ? m.src_a : hi_q;
            lo_d = (m.start && m.op == 4'd6) ? m.src_a : lo_q;
        end else begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
                hi_d    = pend_hi_q;
                lo_d    = pend_lo_q;
                state_d = IDLE;
            end
        end
    end
    // state registers; reset discards any in-flight result
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= 4'd0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
            pend_hi_q <= 32'd0;
            pend_lo_q <= 32'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
        end
    end
    assign m.busy = state_q == BUSY;
    assign m.hi   = hi_q;
    assign m.lo   = lo_q;
endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: vector table plus scoreboard checks of mult_div_unit latency and results
module tb_mult_div_unit;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;
    mdu_if bus();
    mult_div_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (.clk(clk), .reset(reset), .m(bus));
    typedef struct {logic [3:0] op; logic [31:0] a, b, hi, lo; int cyc;} vec_t;
    typedef struct {logic [31:0] hi, lo; int cyc;} exp_t;
    vec_t vt[$];
    exp_t sb[$];
    int cmp = 0;
    int bad = 0;
    logic [31:0] mdl_hi = 32'd0;
    logic [31:0] mdl_lo = 32'd0;
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        cmp++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask
    task automatic add(input logic [3:0] op, input logic [31:0] a, b, hi, lo, input int cyc);
        vec_t v;
        v.op = op; v.a = a; v.b = b; v.hi = hi; v.lo = lo; v.cyc = cyc;
        vt.push_back(v);
    endtask
    task automatic run(input vec_t v, input bit imm, input int inj);
        exp_t e;
        int n = 0;
        if (!imm) @(negedge clk);
        bus.start = 1'b1; bus.op = v.op; bus.src_a = v.a; bus.src_b = v.b;
        @(negedge clk);
        bus.start = 1'b0;
        sb.push_back('{v.hi, v.lo, v.cyc});
        if (v.cyc > 0) begin
            while (bus.busy && n < 40) begin
                n++;
                check("hold_hi", bus.hi, mdl_hi);
                check("hold_lo", bus.lo, mdl_lo);
                bus.start = n == inj;
                if (n == inj) begin bus.op = 4'd1; bus.src_a = 32'd5; bus.src_b = 32'd5; end
                @(negedge clk);
            end
            bus.start = 1'b0;
        end else begin
            repeat (3) begin
                if (bus.busy) n++;
                @(negedge clk);
            end
        end
        e = sb.pop_front();
        check("busy_cycles", n, e.cyc);
        check("hi", bus.hi, e.hi);
        check("lo", bus.lo, e.lo);
        mdl_hi = e.hi;
        mdl_lo = e.lo;
    endtask
    initial begin
        vec_t v;
        reset = 1'b1;
        bus.start = 1'b0; bus.op = 4'd0; bus.src_a = 32'd0; bus.src_b = 32'd0;
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_hi", bus.hi, 32'd0);
        check("rst_lo", bus.lo, 32'd0);
        reset = 1'b0;
        add(4'd1,  32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 32'hFFFFFFFA, 5);
        add(4'd2,  32'hFFFFFFFE, 32'd3,        32'h00000002, 32'hFFFFFFFA, 5);
        add(4'd3,  32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 10);
        add(4'd4,  32'd7,        32'd0,        32'hFFFFFFFF, 32'hFFFFFFFD, 10);
        add(4'd3,  32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 10);
        add(4'd4,  32'd100,      32'd7,        32'd2,        32'd14,       10);
        add(4'd3,  32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 10);
        add(4'd1,  32'h00010000, 32'h00010000, 32'd1,        32'd0,        5);
        add(4'd0,  32'h55,       32'h66,       32'd1,        32'd0,        0);
        add(4'd11, 32'h55,       32'h66,       32'd1,        32'd0,        0);
        add(4'd5,  32'h12345678, 32'h0,        32'h12345678, 32'd0,        0);
        add(4'd6,  32'h9ABCDEF0, 32'h0,        32'h12345678, 32'h9ABCDEF0, 0);
        add(4'd5,  32'h0,        32'h0,        32'h0,        32'h9ABCDEF0, 0);
        add(4'd6,  32'hFFFFFFFF, 32'h0,        32'h0,        32'hFFFFFFFF, 0);
`ifdef MDU_MADD_EN
        add(4'd8,  32'd1,        32'd1,        32'd1,        32'd0,        5);
        add(4'd9,  32'd2,        32'd3,        32'd0,        32'hFFFFFFFA, 5);
        add(4'd7,  32'hFFFFFFFF, 32'd1,        32'd0,        32'hFFFFFFF9, 5);
        add(4'd10, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFE, 32'hFFFFFFFB, 5);
`else
        add(4'd8,  32'd1,        32'd1,        32'd0,        32'hFFFFFFFF, 0);
        add(4'd9,  32'd2,        32'd3,        32'd0,        32'hFFFFFFFF, 0);
        add(4'd7,  32'hFFFFFFFF, 32'd1,        32'd0,        32'hFFFFFFFF, 0);
        add(4'd10, 32'hFFFFFFFF, 32'd2,        32'd0,        32'hFFFFFFFF, 0);
`endif
        foreach (vt[i]) run(vt[i], 1'b0, -1);
        v = '{4'd1, 32'd2, 32'd3, 32'd0, 32'd6, 5};
        run(v, 1'b0, -1);
        v = '{4'd2, 32'd4, 32'd5, 32'd0, 32'd20, 5};
        run(v, 1'b1, -1);
        v = '{4'd1, 32'd3, 32'd4, 32'd0, 32'd12, 5};
        run(v, 1'b0, 2);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("rst2_hi", bus.hi, 32'd0);
        check("rst2_lo", bus.lo, 32'd0);
        bus.start = 1'b1; bus.op = 4'd1; bus.src_a = 32'd5; bus.src_b = 32'd5;
        @(negedge clk);
        bus.start = 1'b0;
        check("mid_busy_on", 32'(bus.busy), 32'd1);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("mid_rst_busy", 32'(bus.busy), 32'd0);
        repeat (10) begin
            @(negedge clk);
            check("discard_busy", 32'(bus.busy), 32'd0);
            check("discard_hi", bus.hi, 32'd0);
            check("discard_lo", bus.lo, 32'd0);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
        $finish;
    end
endmodule
